// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; a single-step build still needs one bit.
  function automatic int cnt_width(input int steps);
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the ripple-chain element of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per clock, LSB first, with valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one chunk per cycle
// DONE  | result held on sum/cout until out_ready
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  import serial_adder_pkg::*;

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if ((WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 2 || WIDTH > 32 || BITS_PER_CYCLE < 1) begin : g_param_err
    $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be 2..32");
  end

  state_t                   state, state_next;
  logic [WIDTH-1:0]         a_sh, b_sh, sum_r, sum_next;
  logic                     carry_r;
  logic [CNT_W-1:0]         cnt;
  logic [BITS_PER_CYCLE:0]  c;
  logic [BITS_PER_CYCLE-1:0] s_chunk;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = RUN;
      RUN:     if (cnt == LAST_STEP)  state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  assign c[0] = carry_r;
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_chain
    full_adder u_fa (
      .a  (a_sh[gi]),
      .b  (b_sh[gi]),
      .ci (c[gi]),
      .s  (s_chunk[gi]),
      .co (c[gi+1])
    );
  end

  // New chunk enters at the MSB end so the full result lands aligned after STEPS shifts.
  assign sum_next = (sum_r >> BITS_PER_CYCLE) | (WIDTH'(s_chunk) << (WIDTH - BITS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            b_sh    <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
`else
            b_sh    <= b;
            carry_r <= cin;
`endif
          end
        end
        RUN: begin
          a_sh    <= a_sh >> BITS_PER_CYCLE;
          b_sh    <= b_sh >> BITS_PER_CYCLE;
          sum_r   <= sum_next;
          carry_r <= c[BITS_PER_CYCLE];
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: one BPC=1 instance and one BPC=4 instance, both WIDTH=8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       in_valid, out_ready, in_ready, out_valid, cout, busy;
  logic [7:0] sum;
  logic       in_valid4, out_ready4, in_ready4, out_valid4, cout4, busy4;
  logic [7:0] sum4;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single op on the BPC=1 instance; hold>0 keeps out_ready low and pushes junk operands meanwhile.
  task automatic op1(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                     input logic vs, input logic [7:0] es, input logic ec, input int hold);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hAA; b = 8'h55; cin = ~vc;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'h11 + 8'(i); b = 8'h22;
      @(negedge clk);
      check({tag, "_hold_sum"}, sum, es);
      check({tag, "_hold_cout"}, cout, ec);
      check({tag, "_hold_rdy"}, in_ready, 1'b0);
      check({tag, "_hold_vld"}, out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_vld"}, out_valid, 1'b0);
    check({tag, "_post_rdy"}, in_ready, 1'b1);
  endtask

  task automatic op4(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                     input logic [7:0] es, input logic ec);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vc; sub = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid4 = 1'b0;
    while (!out_valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_sum"}, sum4, es);
    check({tag, "_cout"}, cout4, ec);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, "_post_rdy"}, in_ready4, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    a = 8'h0; b = 8'h0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_vld", out_valid, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", in_ready, 1'b1);

    op1("basic", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 0);
    op1("wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
    op1("max",   8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0);
    op1("msb",   8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 0);
    op1("bp",    8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 5);

    // Abort after three RUN steps.
    @(negedge clk);
    a = 8'h55; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_vld", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rdy", in_ready, 1'b1);
    check("abort_sum", sum, 8'h00);
    op1("after_abort", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 0);

    op4("wide", 8'h9C, 8'h6B, 1'b1, 8'h08, 1'b1);
    op4("wide_nib", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op1("sub_pos", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0);
    op1("sub_neg", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 0);
    op1("sub_eq",  8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 0);
    op1("sub_off", 8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
